// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// XLEN iterations per operation, one-cycle writeback pulse on completion.
module muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               flush,
  input  logic [2:0]         funct3,
  input  logic [XLEN-1:0]    rs1_val,
  input  logic [XLEN-1:0]    rs2_val,
  input  logic [RADDR_W-1:0] rd_in,
  output logic               busy,
  output logic               done,
  output logic               wb_en,
  output logic [RADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]    wb_data
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0]     LAST_CNT = CW'(XLEN);
  localparam logic [XLEN-1:0]   ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE2     = {{(2*XLEN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [XLEN-1:0]      hi_q, hi_d;
  logic [XLEN-1:0]      lo_q, lo_d;
  logic [XLEN-1:0]      b_q, b_d;
  logic [2:0]           f3_q, f3_d;
  logic [RADDR_W-1:0]   rd_q, rd_d;
  logic                 sa_q, sa_d;
  logic                 sb_q, sb_d;
  logic                 bz_q, bz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wb_en_q, wb_en_d;
  logic [RADDR_W-1:0]   wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]      wb_data_q, wb_data_d;

  logic                 a_signed_s, b_signed_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]      a_mag_s, b_mag_s;
  logic [XLEN:0]        mul_sum_s, rem_sh_s, div_diff_s;
  logic [2*XLEN-1:0]    prod_s;
  logic [XLEN-1:0]      result_s;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + ONE;
  endfunction

  // Next-state, datapath iteration and result selection
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    b_d       = b_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    bz_d      = bz_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;

    // Signedness per funct3: DIV/REM signed on both, MULH both, MULHSU rs1 only
    if (funct3[2]) begin
      a_signed_s = ~funct3[0];
      b_signed_s = ~funct3[0];
    end else begin
      a_signed_s = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
      b_signed_s = (funct3[1:0] == 2'b01);
    end
    a_neg_s = a_signed_s & rs1_val[XLEN-1];
    b_neg_s = b_signed_s & rs2_val[XLEN-1];
    a_mag_s = a_neg_s ? neg_x(rs1_val) : rs1_val;
    b_mag_s = b_neg_s ? neg_x(rs2_val) : rs2_val;

    mul_sum_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    rem_sh_s   = {hi_q, lo_q[XLEN-1]};
    div_diff_s = rem_sh_s - {1'b0, b_q};

    if (sa_q ^ sb_q) begin
      prod_s = ~{hi_q, lo_q} + ONE2;
    end else begin
      prod_s = {hi_q, lo_q};
    end

    case (f3_q)
      3'b000:         result_s = prod_s[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         result_s = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101: result_s = bz_q ? {XLEN{1'b1}} : ((sa_q ^ sb_q) ? neg_x(lo_q) : lo_q);
      3'b110, 3'b111: result_s = sa_q ? neg_x(hi_q) : hi_q;
      default:        result_s = {XLEN{1'b0}};
    endcase

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d = S_CALC;
          busy_d  = 1'b1;
          count_d = {CW{1'b0}};
          f3_d    = funct3;
          rd_d    = rd_in;
          sa_d    = a_neg_s;
          sb_d    = b_neg_s;
          bz_d    = (rs2_val == {XLEN{1'b0}});
          hi_d    = {XLEN{1'b0}};
          // Multiply shifts the multiplier (rs2) out of lo; divide shifts the dividend (rs1)
          if (funct3[2]) begin
            lo_d = a_mag_s;
            b_d  = b_mag_s;
          end else begin
            lo_d = b_mag_s;
            b_d  = a_mag_s;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (count_q == LAST_CNT) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          wb_en_d   = |rd_q;
          wb_rd_d   = rd_q;
          wb_data_d = result_s;
        end else begin
          count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
          if (f3_q[2]) begin
            if (!div_diff_s[XLEN]) begin
              hi_d = div_diff_s[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_d = rem_sh_s[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            hi_d = mul_sum_s[XLEN:1];
            lo_d = {mul_sum_s[0], lo_q[XLEN-1:1]};
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= {CW{1'b0}};
      hi_q      <= {XLEN{1'b0}};
      lo_q      <= {XLEN{1'b0}};
      b_q       <= {XLEN{1'b0}};
      f3_q      <= 3'b000;
      rd_q      <= {RADDR_W{1'b0}};
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      bz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= {RADDR_W{1'b0}};
      wb_data_q <= {XLEN{1'b0}};
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      b_q       <= b_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      bz_q      <= bz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  // A squash in the completion cycle must suppress the writeback immediately
  assign busy    = busy_q;
  assign done    = done_q & ~flush;
  assign wb_en   = wb_en_q & ~flush;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results queued at issue, compared on done.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        en;
  } exp_t;

  exp_t exp_queue[$];
  exp_t mon_e;
  int   tests_run;
  int   tests_failed;

  localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
  localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

  muldiv_unit #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
    .busy(busy), .done(done), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'd0;
    case (f)
      F_MUL:    begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      F_MULH:   begin p = sa * sb; return p[63:32]; end
      F_MULHSU: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      F_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      F_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        else begin p = sa / sb; return p[31:0]; end
      end
      F_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      F_REM: begin
        if (b == 32'd0) return a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        else begin p = sa % sb; return p[31:0]; end
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Scoreboard: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      tests_run = tests_run + 1;
      if (exp_queue.size() == 0) begin
        tests_failed = tests_failed + 1;
        $display("FAIL unexpected_done: got wb_data=%h wb_rd=%0d, required no done", wb_data, wb_rd);
      end else begin
        mon_e = exp_queue.pop_front();
        if (wb_data !== mon_e.data || wb_rd !== mon_e.rd || wb_en !== mon_e.en) begin
          tests_failed = tests_failed + 1;
          $display("FAIL result: got data=%h rd=%0d en=%b, required data=%h rd=%0d en=%b",
                   wb_data, wb_rd, wb_en, mon_e.data, mon_e.rd, mon_e.en);
        end
      end
    end
  end

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int   cyc;
    exp_t e;
    funct3 = f; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e.data = model(f, a, b); e.rd = rd; e.en = (rd != 5'd0);
    exp_queue.push_back(e);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_after_start: got %b, required 1", busy);
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    tests_run++;
    if (cyc != 33) begin
      tests_failed++;
      $display("FAIL latency f3=%0d: got %0d cycles, required 33", f, cyc);
    end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0 || wb_en !== 1'b0 || busy !== 1'b0 || wb_data !== e.data || wb_rd !== rd) begin
      tests_failed++;
      $display("FAIL after_done: got done=%b wb_en=%b busy=%b data=%h rd=%0d, required 0/0/0 data=%h rd=%0d",
               done, wb_en, busy, wb_data, wb_rd, e.data, rd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0;
    rs1_val = 32'd0; rs2_val = 32'd0; rd_in = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || wb_en !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got busy=%b done=%b wb_en=%b rd=%0d data=%h, required all 0",
               busy, done, wb_en, wb_rd, wb_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_op(F_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5);
    do_op(F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1);
    do_op(F_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2);
    do_op(F_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd3);
    do_op(F_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd4);
    do_op(F_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd6);
    do_op(F_REM,    32'hFFFF_FFF9,  32'd2,         5'd7);
    do_op(F_DIVU,   32'd100,        32'd7,         5'd8);
    do_op(F_DIVU,   32'd100,        32'd0,         5'd9);
    do_op(F_REMU,   32'd100,        32'd0,         5'd10);
    do_op(F_DIV,    32'hFFFF_FFFB,  32'd0,         5'd11);
    do_op(F_REM,    32'hFFFF_FFFB,  32'd0,         5'd12);
    do_op(F_DIV,    32'hFFFF_FFF9,  32'd2,         5'd13);
    do_op(F_MUL,    32'd3,          32'd4,         5'd0);
  endtask

  task automatic test_random();
    logic [31:0] b;
    for (int i = 0; i < 16; i++) begin
      b = (i % 4 == 0) ? 32'd0 : ((i % 4 == 1) ? $urandom_range(255, 1) : $urandom);
      do_op(3'($urandom_range(7, 0)), $urandom, b, 5'($urandom_range(31, 0)));
    end
  endtask

  task automatic test_start_ignored();
    int   cyc;
    exp_t e;
    funct3 = F_MUL; rs1_val = 32'd1000; rs2_val = 32'd3; rd_in = 5'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e.data = model(F_MUL, 32'd1000, 32'd3); e.rd = 5'd20; e.en = 1'b1;
    exp_queue.push_back(e);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 5) begin
        funct3 = F_DIVU; rs1_val = 32'd123; rs2_val = 32'd456; rd_in = 5'd9; start = 1'b1;
      end else if (cyc == 8) begin
        start = 1'b0;
      end
    end
    tests_run++;
    if (cyc != 33) begin
      tests_failed++;
      $display("FAIL start_in_calc_latency: got %0d cycles, required 33", cyc);
    end
    // start held through the DONE cycle must not launch a new op
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_in_done: got busy=%b, required 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    funct3 = F_MULHU; rs1_val = 32'hDEAD_BEEF; rs2_val = 32'h1234_5678; rd_in = 5'd15; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_calc: got busy=%b done=%b, required 0/0", busy, done);
    end
    do_op(F_DIVU, 32'd1000, 32'd9, 5'd16);
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_wins_idle: got busy=%b, required 0", busy);
    end
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic test_rst_mid();
    funct3 = F_DIV; rs1_val = 32'd77; rs2_val = 32'd5; rd_in = 5'd21; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || wb_en !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_op: got busy=%b done=%b wb_en=%b rd=%0d data=%h, required all 0",
               busy, done, wb_en, wb_rd, wb_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_idle_after: got busy=%b, required 0", busy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_flush();
    test_rst_mid();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (exp_queue.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_queue.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
